// File: rtl/ifu_pkg.sv
// Shared types and widths for the instruction fetch unit.
package ifu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ENTRY_W = 2 * XLEN;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_queue.sv
// Small circular FIFO holding fetched {pc, inst} pairs; flush empties it in one cycle.
module ifu_queue
   import ifu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [ENTRY_W-1:0]      data_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   output logic [ENTRY_W-1:0]      head_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    empty_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]      wr_q, wr_d;
   logic [PW-1:0]      rd_q, rd_d;
   logic [CW-1:0]      count_q, count_d;
   logic               do_push;
   logic               do_pop;

   // Flush wins over any push/pop in the same cycle.
   always_comb begin
      do_push = push_i && !flush_i;
      do_pop  = pop_i && !flush_i && (count_q != '0);
      mem_d   = mem_q;
      wr_d    = wr_q + PW'(do_push);
      rd_d    = rd_q + PW'(do_pop);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) begin
         mem_d[wr_q] = data_i;
      end
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches and
// queues returned instructions toward if_id; ex redirects flush the stream.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            jump_en_i,
   input  logic [XLEN-1:0] jump_addr_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] instaddr_o
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   logic [XLEN-1:0]    pc_q, pc_d;
   logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]      outstanding_q, outstanding_d;
   logic [CW-1:0]      discard_q, discard_d;
   logic               gnt_fire;
   logic               q_push;
   logic               q_pop;
   logic               q_empty;
   logic [CW-1:0]      q_count;
   logic [ENTRY_W-1:0] q_head_raw;
   fetch_entry_t       q_head;
   fetch_entry_t       q_wdata;

   // Credit rule: queued + in-flight words never exceed the queue depth.
   always_comb begin
      imem_req_o    = !rst && !jump_en_i &&
                      ((SW'(q_count) + SW'(outstanding_q)) < SW'(QDEPTH));
      gnt_fire      = imem_req_o && imem_gnt_i;
      pc_d          = pc_q;
      rsp_pc_d      = rsp_pc_q;
      discard_d     = discard_q;
      q_push        = 1'b0;
      outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid_i);
      if (gnt_fire) begin
         pc_d     = pc_q + XLEN'(4);
         rsp_pc_d = pc_q;
      end
      if (imem_rvalid_i) begin
         if (discard_q != '0) begin
            discard_d = discard_q - CW'(1);
         end else begin
            q_push = 1'b1;
         end
      end
      // Redirect: words still in flight after this cycle belong to the old stream.
      if (jump_en_i) begin
         pc_d      = word_align(jump_addr_i);
         discard_d = outstanding_d;
      end
      q_pop = inst_valid_o && inst_ready_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         pc_q          <= pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   assign q_wdata = '{pc: rsp_pc_q, inst: imem_rdata_i};

   ifu_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .push_i  (q_push),
      .data_i  (q_wdata),
      .pop_i   (q_pop),
      .flush_i (jump_en_i),
      .head_o  (q_head_raw),
      .count_o (q_count),
      .empty_o (q_empty)
   );

   assign q_head       = fetch_entry_t'(q_head_raw);
   assign imem_addr_o  = word_align(pc_q);
   assign inst_valid_o = !q_empty;
   assign inst_o       = q_empty ? '0 : q_head.inst;
   assign instaddr_o   = q_empty ? '0 : q_head.pc;

endmodule

// File: tb/tb_ifu.sv
// Directed table-driven bench for ifu with a 1-cycle-latency instruction memory.
module tb_ifu;
   import ifu_pkg::*;

   localparam int unsigned QDEPTH   = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] K        = 32'hA5A5_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] instaddr_o;

   int checks = 0;
   int errors = 0;

   ifu #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .jump_en_i     (jump_en_i),
      .jump_addr_i   (jump_addr_i),
      .inst_valid_o  (inst_valid_o),
      .inst_ready_i  (inst_ready_i),
      .inst_o        (inst_o),
      .instaddr_o    (instaddr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: every granted request returns addr^K exactly one cycle later.
   always @(posedge clk) begin
      if (rst) begin
         imem_rvalid_i <= 1'b0;
         imem_rdata_i  <= 32'h0;
      end else begin
         imem_rvalid_i <= imem_req_o && imem_gnt_i;
         imem_rdata_i  <= imem_addr_o ^ K;
      end
   end

   // A push into a full queue without a simultaneous pop must never happen.
   always @(posedge clk) begin
      if (!rst && dut.u_queue.do_push && !dut.u_queue.do_pop &&
          int'(dut.u_queue.count_q) == int'(QDEPTH)) begin
         errors++;
         $display("FAIL push_full: push into full queue at %0t", $time);
      end
   end

   typedef struct {
      logic        start;
      logic        gnt;
      logic        rdy;
      logic        jmp;
      logic [31:0] jaddr;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] eiaddr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic g, input logic r, input logic j,
                      input logic [31:0] ja, input logic er, input logic [31:0] ea,
                      input logic ev, input logic [31:0] eia);
      vec_t v;
      v.start = st; v.gnt = g; v.rdy = r; v.jmp = j; v.jaddr = ja;
      v.ereq = er; v.eaddr = ea; v.evalid = ev; v.eiaddr = eia;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic er, input logic [31:0] ea,
                        input logic ev, input logic [31:0] ei, input logic [31:0] eia);
      checks++;
      if ({imem_req_o, imem_addr_o, inst_valid_o, inst_o, instaddr_o} !== {er, ea, ev, ei, eia}) begin
         errors++;
         $display("FAIL %s: got req=%0b addr=%h valid=%0b inst=%h iaddr=%h, want req=%0b addr=%h valid=%0b inst=%h iaddr=%h",
                  name, imem_req_o, imem_addr_o, inst_valid_o, inst_o, instaddr_o, er, ea, ev, ei, eia);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; imem_gnt_i = 1'b0; inst_ready_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0;
      @(negedge clk);
      #1;
      check("reset", 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; imem_gnt_i = 1'b0; inst_ready_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0;

      //  st g  r  j  jaddr          req addr           v  iaddr
      // free-running fetch, ready always high
      add(1, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h8,          1, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4);
      add(0, 1, 1, 0, 32'h0,          1, 32'hC,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h10,         1, 32'h8);
      add(0, 1, 1, 0, 32'h0,          1, 32'h10,         1, 32'hC);
      // stall: queue fills, one pop frees one credit
      add(1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
      add(0, 1, 0, 0, 32'h0,          0, 32'h8,          1, 32'h0);
      add(0, 1, 0, 0, 32'h0,          0, 32'h8,          1, 32'h0);
      add(0, 1, 0, 0, 32'h0,          0, 32'h8,          1, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h8,          1, 32'h0);
      add(0, 1, 0, 0, 32'h0,          1, 32'h8,          1, 32'h4);
      add(0, 1, 0, 0, 32'h0,          0, 32'hC,          1, 32'h4);
      add(0, 1, 0, 0, 32'h0,          0, 32'hC,          1, 32'h4);
      // grant withheld three cycles
      add(1, 0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h8,          1, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4);
      // jump with a fetch in flight, unaligned target
      add(1, 1, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 0, 1, 32'h103,        0, 32'h4,          0, 32'h0);
      add(0, 1, 0, 0, 32'h0,          1, 32'h100,        0, 32'h0);
      add(0, 1, 0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
      add(0, 1, 0, 0, 32'h0,          0, 32'h108,        1, 32'h100);
      // jump coinciding with rvalid and a pop
      add(1, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0);
      add(0, 1, 1, 1, 32'h200,        0, 32'h8,          1, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h200,        0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h204,        0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h208,        1, 32'h200);
      // back-to-back jumps: last one wins
      add(1, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 1, 1, 32'h200,        0, 32'h4,          0, 32'h0);
      add(0, 1, 1, 1, 32'h300,        0, 32'h200,        0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h300,        0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h304,        0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h308,        1, 32'h300);
      // PC wrap from the top of the address space
      add(1, 1, 1, 1, 32'hFFFF_FFFE,  0, 32'h0,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0);
      add(0, 1, 1, 0, 32'h0,          0, 32'h4,          1, 32'hFFFF_FFFC);

      foreach (vecs[i]) begin
         if (vecs[i].start) do_reset();
         @(negedge clk);
         rst          = 1'b0;
         imem_gnt_i   = vecs[i].gnt;
         inst_ready_i = vecs[i].rdy;
         jump_en_i    = vecs[i].jmp;
         jump_addr_i  = vecs[i].jaddr;
         #1;
         check($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid,
               vecs[i].evalid ? (vecs[i].eiaddr ^ K) : 32'h0, vecs[i].eiaddr);
      end

      // Reset mid-stream with a full queue.
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         rst = 1'b0; imem_gnt_i = 1'b1; inst_ready_i = 1'b0; jump_en_i = 1'b0;
      end
      #1;
      check("full_before_rst", 1'b0, 32'h8, 1'b1, K, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_req: got req=%0b want 0", imem_req_o);
      end
      @(negedge clk);
      #1;
      check("rst_mid", 1'b0, RESET_PC, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0; inst_ready_i = 1'b1;
      #1;
      check("rst_rel0", 1'b1, RESET_PC, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check("rst_rel1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check("rst_rel2", 1'b0, 32'h8, 1'b1, K, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
